prog_instr_memory: RTL and testbench

PROG_INSTR_MEMORY -- requirements
Module: prog_instr_memory

---
 rtl/prog_instr_memory.sv | 128 ++++++++++++
 tb/tb_prog_instr_memory.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_instr_memory.sv
// Byte-addressed program memory: cleared by a sweep after reset, then accepts
// big-endian instruction loads and single-cycle-latency instruction fetches.
module prog_instr_memory #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               misaligned,
  output logic               halt,
  output logic               busy
);

  localparam int BYTES = INSTR_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                misaligned_q, misaligned_d;
  logic                halt_q, halt_d;

  logic [7:0]          mem_q [DEPTH];

  logic                run;
  logic                load_acc;
  logic                fetch_acc;
  logic                clr_we;
  logic [INSTR_W-1:0]  rd_word;

  // Byte address offset from a base, wrapping modulo the memory depth.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] base,
                                                 input int                off);
    return base + ADDR_W'(off);
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (32'(addr) % 32'(BYTES)) != 32'd0;
  endfunction

  assign run        = (state_q == RUN);
  assign busy       = ~run;
  assign load_ready = run;
  assign load_acc   = load_valid & run;
  assign fetch_acc  = fetch_en & run;
  assign clr_we     = ~run & reset_n;

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign misaligned  = misaligned_q;
  assign halt        = halt_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d   = RUN;
        clr_cnt_d = '0;
      end
    end
  end

  // Read port: old array contents, so a same-cycle load is not visible yet.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BYTES; i++) begin
      rd_word[INSTR_W-1-8*i -: 8] = mem_q[wrap_add(fetch_addr, i)];
    end
  end

  always_comb begin
    instr_d       = instr_q;
    misaligned_d  = misaligned_q;
    halt_d        = halt_q;
    instr_valid_d = fetch_acc;
    if (fetch_acc) begin
      instr_d      = rd_word;
      misaligned_d = is_misaligned(fetch_addr);
      halt_d       = (rd_word == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= CLEAR;
      clr_cnt_q     <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      halt_q        <= halt_d;
    end
  end

  // Storage has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= 8'h00;
    end else if (load_acc) begin
      for (int i = 0; i < BYTES; i++) begin
        mem_q[wrap_add(load_addr, i)] <= load_data[INSTR_W-1-8*i -: 8];
      end
    end
  end

endmodule

// File: tb/tb_prog_instr_memory.sv
// Scoreboard bench for prog_instr_memory (ADDR_W=8, INSTR_W=16) using directed
// vectors with hand-computed expected words.
module tb_prog_instr_memory;

  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          misaligned;
  logic          halt;
  logic          busy;

  prog_instr_memory #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .misaligned (misaligned),
    .halt       (halt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] word;
    logic          mis;
    logic          hlt;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    fetch_en   = 1'b0;
    fetch_addr = '0;
  endtask

  // One clock of stimulus; a fetch pushes its expected response.
  task automatic drive(input logic lv, input logic [AW-1:0] la, input logic [IW-1:0] ld,
                       input logic fe, input logic [AW-1:0] fa,
                       input logic [IW-1:0] ew, input logic em, input logic eh);
    exp_t e;
    load_valid = lv;
    load_addr  = la;
    load_data  = ld;
    fetch_en   = fe;
    fetch_addr = fa;
    if (fe) begin
      e.word = ew;
      e.mis  = em;
      e.hlt  = eh;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    step();
    clear_inputs();
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    drive(1'b1, a, d, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [IW-1:0] ew,
                       input logic em, input logic eh);
    drive(1'b0, '0, '0, 1'b1, a, ew, em, eh);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},       64'(busy),        64'd1);
    chk({tag, "_load_ready"}, 64'(load_ready),  64'd0);
    chk({tag, "_instr"},      64'(instr),       64'd0);
    chk({tag, "_valid"},      64'(instr_valid), 64'd0);
    chk({tag, "_misaligned"}, 64'(misaligned),  64'd0);
    chk({tag, "_halt"},       64'(halt),        64'd0);
  endtask

  // Count cycles until busy drops, with fetch_en optionally held throughout.
  task automatic sweep(input string tag, input logic hold_fetch);
    int n;
    n = 0;
    fetch_en   = hold_fetch;
    fetch_addr = 8'h00;
    while (busy === 1'b1 && n < 1000) begin
      step();
      n++;
    end
    fetch_en = 1'b0;
    chk({tag, "_len"},        64'(n),          64'd256);
    chk({tag, "_busy_done"},  64'(busy),       64'd0);
    chk({tag, "_load_ready"}, 64'(load_ready), 64'd1);
  endtask

  // Monitor: every presented word must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'(instr_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr",      64'(instr),      64'(e.word));
        chk("misaligned", 64'(misaligned), 64'(e.mis));
        chk("halt",       64'(halt),       64'(e.hlt));
        chk("latency",    64'(cyc),        64'(e.cyc));
      end
    end
  end

  initial begin
    int w;
    clear_inputs();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("por");
    step();
    step();
    reset_n = 1'b1;
    sweep("sweep0", 1'b0);

    fetch(8'h00, 16'h0000, 1'b0, 1'b1);

    load(8'h00, 16'h21FE);
    load(8'h02, 16'h22FB);
    fetch(8'h00, 16'h21FE, 1'b0, 1'b0);
    fetch(8'h02, 16'h22FB, 1'b0, 1'b0);
    fetch(8'h01, 16'hFE22, 1'b1, 1'b0);

    load(8'hFF, 16'hABCD);
    fetch(8'hFF, 16'hABCD, 1'b1, 1'b0);
    fetch(8'h00, 16'hCDFE, 1'b0, 1'b0);

    load(8'h10, 16'h1111);
    drive(1'b1, 8'h10, 16'h9AD5, 1'b1, 8'h10, 16'h1111, 1'b0, 1'b0);
    fetch(8'h10, 16'h9AD5, 1'b0, 1'b0);
    step();
    chk("hold_valid", 64'(instr_valid), 64'd0);
    chk("hold_instr", 64'(instr),       64'h9AD5);
    chk("hold_mis",   64'(misaligned),  64'd0);
    chk("hold_halt",  64'(halt),        64'd0);

    fetch(8'h41, 16'h0000, 1'b1, 1'b1);
    fetch(8'h02, 16'h22FB, 1'b0, 1'b0);
    step();

    // Asynchronous reset while holding nonzero outputs.
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async");
    step();
    reset_n = 1'b1;
    fetch_en = 1'b1;
    for (int i = 0; i < 100; i++) step();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midsweep");
    step();
    reset_n = 1'b1;
    sweep("sweep1", 1'b1);

    fetch(8'h00, 16'h0000, 1'b0, 1'b1);
    fetch(8'h10, 16'h0000, 1'b0, 1'b1);
    fetch(8'hFF, 16'h0000, 1'b1, 1'b1);

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      step();
      w++;
    end
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
